// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: behavioural stand-in for the XADC DRP slave port.
// A two-channel sequencer (VAUX6 = X, VAUX7 = Y) converts digital sample inputs,
// and a DRP responder serves results plus a small config space with a fixed
// read latency.
// Optional macro XADC_DRP_AVG_EN: each channel reports the truncated mean of its
// last four samples instead of the raw sample.
module xadc_drp_responder #(
   parameter int unsigned READ_LATENCY = 4,
   parameter int unsigned CONV_CYCLES  = 26,
   parameter bit          RESET_SEQ_EN = 1'b1
) (
   input  logic        clk_100MHz,
   input  logic        rst,
   input  logic [6:0]  daddr_in,
   input  logic        den_in,
   input  logic        dwe_in,
   input  logic [15:0] di_in,
   output logic [15:0] do_out,
   output logic        drdy_out,
   input  logic [11:0] sample_x,
   input  logic [11:0] sample_y,
   output logic [4:0]  channel_out,
   output logic        eoc_out,
   output logic        busy_out,
   output logic        err_out
);

   localparam logic [6:0] AddrResX   = 7'h16;
   localparam logic [6:0] AddrResY   = 7'h17;
   localparam logic [6:0] AddrCfg0   = 7'h40;
   localparam logic [6:0] AddrSeqCtl = 7'h41;

   localparam logic [3:0] LatInit  = 4'(READ_LATENCY - 1);
   localparam logic [7:0] ConvInit = 8'(CONV_CYCLES - 1);

   typedef enum logic [0:0] {DrpIdle, DrpWait} drp_st_e;
   typedef enum logic [1:0] {SeqIdle, SeqConvert, SeqStore} seq_st_e;

   // DRP responder state
   drp_st_e     drp_st_q, drp_st_d;
   logic [3:0]  lat_cnt_q, lat_cnt_d;
   logic [6:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] snap_q, snap_d;
   logic [15:0] do_q, do_d;
   logic        drdy_q, drdy_d;
   logic        err_q, err_d;

   // Register file
   logic [11:0] res_x_q, res_x_d;
   logic [11:0] res_y_q, res_y_d;
   logic [15:0] cfg_q, cfg_d;
   logic        seq_en_q, seq_en_d;

   // Sequencer state
   seq_st_e     seq_st_q, seq_st_d;
   logic [7:0]  conv_cnt_q, conv_cnt_d;
   logic        ch7_q, ch7_d;
   logic [4:0]  chan_q, chan_d;
   logic        eoc_q, eoc_d;
   logic        busy_q, busy_d;

`ifdef XADC_DRP_AVG_EN
   logic [2:0][11:0] hist_x_q, hist_x_d;
   logic [2:0][11:0] hist_y_q, hist_y_d;
   logic [2:0][11:0] hist_sel;
   logic [13:0]      avg_sum;
`endif

   logic [15:0] rd_data;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [15:0] wr_data;
   logic [11:0] samp_sel;
   logic [11:0] new_res;

   // Register read mux on the live address; captured as the snapshot on accept
   always_comb begin
      rd_data = 16'h0000;
      case (daddr_in)
         AddrResX:   rd_data = {res_x_q, 4'h0};
         AddrResY:   rd_data = {res_y_q, 4'h0};
         AddrCfg0:   rd_data = cfg_q;
         AddrSeqCtl: rd_data = {15'h0000, seq_en_q};
         default:    rd_data = 16'h0000;
      endcase
   end

   // DRP transaction FSM next-state, including the write decode at completion
   always_comb begin
      drp_st_d  = drp_st_q;
      lat_cnt_d = lat_cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      snap_d    = snap_q;
      do_d      = do_q;
      drdy_d    = 1'b0;
      err_d     = err_q;
      cfg_d     = cfg_q;
      seq_en_d  = seq_en_q;
      wr_en     = 1'b0;
      wr_addr   = addr_q;
      wr_data   = wdata_q;
      unique case (drp_st_q)
         DrpIdle: begin
            if (den_in) begin
               // A request landing on the drdy cycle is a protocol error
               if (drdy_q) begin
                  err_d = 1'b1;
               end else begin
                  addr_d  = daddr_in;
                  we_d    = dwe_in;
                  wdata_d = di_in;
                  snap_d  = rd_data;
                  if (READ_LATENCY <= 1) begin
                     drdy_d = 1'b1;
                     if (dwe_in) begin
                        wr_en   = 1'b1;
                        wr_addr = daddr_in;
                        wr_data = di_in;
                     end else begin
                        do_d = rd_data;
                     end
                  end else begin
                     lat_cnt_d = LatInit;
                     drp_st_d  = DrpWait;
                  end
               end
            end
         end
         DrpWait: begin
            if (den_in) begin
               err_d = 1'b1;
            end
            if (lat_cnt_q == 4'd1) begin
               drdy_d   = 1'b1;
               drp_st_d = DrpIdle;
               if (we_q) begin
                  wr_en = 1'b1;
               end else begin
                  do_d = snap_q;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         default: drp_st_d = DrpIdle;
      endcase
      if (wr_en) begin
         case (wr_addr)
            AddrCfg0:   cfg_d    = wr_data;
            AddrSeqCtl: seq_en_d = wr_data[0];
            default:    ;
         endcase
      end
   end

   // Conversion sequencer next-state and result capture in STORE
   always_comb begin
      seq_st_d   = seq_st_q;
      conv_cnt_d = conv_cnt_q;
      ch7_d      = ch7_q;
      chan_d     = chan_q;
      eoc_d      = eoc_q;
      busy_d     = busy_q;
      res_x_d    = res_x_q;
      res_y_d    = res_y_q;
      samp_sel   = ch7_q ? sample_y : sample_x;
`ifdef XADC_DRP_AVG_EN
      hist_x_d = hist_x_q;
      hist_y_d = hist_y_q;
      hist_sel = ch7_q ? hist_y_q : hist_x_q;
      avg_sum  = 14'(samp_sel) + 14'(hist_sel[0]) + 14'(hist_sel[1]) + 14'(hist_sel[2]);
      new_res  = 12'(avg_sum >> 2);
`else
      new_res  = samp_sel;
`endif
      unique case (seq_st_q)
         SeqIdle: begin
            if (seq_en_q) begin
               seq_st_d   = SeqConvert;
               busy_d     = 1'b1;
               conv_cnt_d = ConvInit;
               ch7_d      = 1'b0;
            end
         end
         SeqConvert: begin
            if (conv_cnt_q == 8'd0) begin
               seq_st_d = SeqStore;
               busy_d   = 1'b0;
               eoc_d    = 1'b1;
               chan_d   = ch7_q ? 5'd7 : 5'd6;
            end else begin
               conv_cnt_d = conv_cnt_q - 8'd1;
            end
         end
         SeqStore: begin
            eoc_d = 1'b0;
            if (ch7_q) begin
               res_y_d = new_res;
`ifdef XADC_DRP_AVG_EN
               hist_y_d = {hist_y_q[1], hist_y_q[0], samp_sel};
`endif
            end else begin
               res_x_d = new_res;
`ifdef XADC_DRP_AVG_EN
               hist_x_d = {hist_x_q[1], hist_x_q[0], samp_sel};
`endif
            end
            ch7_d = ~ch7_q;
            if (seq_en_q) begin
               seq_st_d   = SeqConvert;
               busy_d     = 1'b1;
               conv_cnt_d = ConvInit;
            end else begin
               seq_st_d = SeqIdle;
            end
         end
         default: seq_st_d = SeqIdle;
      endcase
   end

   // All state and registered outputs; synchronous reset drops any pending request
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         drp_st_q   <= DrpIdle;
         lat_cnt_q  <= 4'd0;
         addr_q     <= 7'd0;
         we_q       <= 1'b0;
         wdata_q    <= 16'h0000;
         snap_q     <= 16'h0000;
         do_q       <= 16'h0000;
         drdy_q     <= 1'b0;
         err_q      <= 1'b0;
         res_x_q    <= 12'h000;
         res_y_q    <= 12'h000;
         cfg_q      <= 16'h0000;
         seq_en_q   <= RESET_SEQ_EN;
         seq_st_q   <= SeqIdle;
         conv_cnt_q <= 8'd0;
         ch7_q      <= 1'b0;
         chan_q     <= 5'd0;
         eoc_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef XADC_DRP_AVG_EN
         hist_x_q   <= '0;
         hist_y_q   <= '0;
`endif
      end else begin
         drp_st_q   <= drp_st_d;
         lat_cnt_q  <= lat_cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         snap_q     <= snap_d;
         do_q       <= do_d;
         drdy_q     <= drdy_d;
         err_q      <= err_d;
         res_x_q    <= res_x_d;
         res_y_q    <= res_y_d;
         cfg_q      <= cfg_d;
         seq_en_q   <= seq_en_d;
         seq_st_q   <= seq_st_d;
         conv_cnt_q <= conv_cnt_d;
         ch7_q      <= ch7_d;
         chan_q     <= chan_d;
         eoc_q      <= eoc_d;
         busy_q     <= busy_d;
`ifdef XADC_DRP_AVG_EN
         hist_x_q   <= hist_x_d;
         hist_y_q   <= hist_y_d;
`endif
      end
   end

   assign do_out      = do_q;
   assign drdy_out    = drdy_q;
   assign err_out     = err_q;
   assign channel_out = chan_q;
   assign eoc_out     = eoc_q;
   assign busy_out    = busy_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Testbench for xadc_drp_responder: directed scenarios with literal expectations,
// then randomized DRP traffic, all checked every cycle against a behavioural model.
module tb_xadc_drp_responder;

   localparam int Lat  = 4;
   localparam int Conv = 26;

   logic        clk_100MHz = 1'b0;
   logic        rst        = 1'b1;
   logic [6:0]  daddr_in   = 7'h00;
   logic        den_in     = 1'b0;
   logic        dwe_in     = 1'b0;
   logic [15:0] di_in      = 16'h0000;
   logic [11:0] sample_x   = 12'h800;
   logic [11:0] sample_y   = 12'h3E8;
   logic [15:0] do_out;
   logic        drdy_out;
   logic [4:0]  channel_out;
   logic        eoc_out;
   logic        busy_out;
   logic        err_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   xadc_drp_responder #(
      .READ_LATENCY(Lat),
      .CONV_CYCLES (Conv),
      .RESET_SEQ_EN(1'b1)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .daddr_in   (daddr_in),
      .den_in     (den_in),
      .dwe_in     (dwe_in),
      .di_in      (di_in),
      .do_out     (do_out),
      .drdy_out   (drdy_out),
      .sample_x   (sample_x),
      .sample_y   (sample_y),
      .channel_out(channel_out),
      .eoc_out    (eoc_out),
      .busy_out   (busy_out),
      .err_out    (err_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   logic [15:0] m_do;
   bit          m_drdy, m_err, m_eoc, m_busy;
   logic [4:0]  m_chan;
   logic [11:0] m_res [2];
   logic [15:0] m_cfg;
   bit          m_seq_en;
   bit          m_active;   // a conversion (CONVERT or STORE) is in progress
   int          m_pos;      // 1..Conv = converting cycle, Conv+1 = store cycle
   int          m_ch;
   bit          m_pend;
   int          m_due;
   int          n;
   logic [6:0]  p_addr;
   bit          p_we;
   logic [15:0] p_di, p_snap;
   int          m_hist [2][3];

   function automatic logic [15:0] m_read(input logic [6:0] a);
      case (a)
         7'h16:   return {m_res[0], 4'h0};
         7'h17:   return {m_res[1], 4'h0};
         7'h40:   return m_cfg;
         7'h41:   return {15'h0000, m_seq_en};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step();
      bit old_drdy;
      bit se;
      int idx;
      int s;
      int sum;
      if (rst) begin
         m_do = 16'h0; m_drdy = 0; m_err = 0; m_eoc = 0; m_busy = 0; m_chan = 5'd0;
         m_res[0] = 12'h0; m_res[1] = 12'h0; m_cfg = 16'h0; m_seq_en = 1'b1;
         m_active = 0; m_pos = 0; m_ch = 6; m_pend = 0; m_due = 0; n = 0;
         for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) m_hist[i][j] = 0;
         m_valid = 1'b1;
         return;
      end
      n++;
      old_drdy = m_drdy;
      m_drdy   = 1'b0;
      // request acceptance snapshots the register map before this edge's updates
      if (den_in) begin
         if (m_pend || old_drdy) begin
            m_err = 1'b1;
         end else begin
            m_pend = 1'b1;
            p_addr = daddr_in;
            p_we   = dwe_in;
            p_di   = di_in;
            p_snap = m_read(daddr_in);
            m_due  = n + Lat - 1;
         end
      end
      se = m_seq_en;
      if (!m_active) begin
         if (se) begin
            m_active = 1'b1;
            m_pos    = 1;
            m_ch     = 6;
         end
      end else if (m_pos == Conv + 1) begin
         idx = (m_ch == 7) ? 1 : 0;
         s   = (idx == 1) ? int'(sample_y) : int'(sample_x);
`ifdef XADC_DRP_AVG_EN
         sum = s + m_hist[idx][0] + m_hist[idx][1] + m_hist[idx][2];
         m_res[idx] = 12'(sum / 4);
         m_hist[idx][2] = m_hist[idx][1];
         m_hist[idx][1] = m_hist[idx][0];
         m_hist[idx][0] = s;
`else
         sum = s;
         m_res[idx] = 12'(sum);
`endif
         m_ch = (m_ch == 6) ? 7 : 6;
         if (se) m_pos = 1;
         else m_active = 1'b0;
      end else begin
         m_pos++;
      end
      m_busy = m_active && (m_pos <= Conv);
      m_eoc  = m_active && (m_pos == Conv + 1);
      if (m_eoc) m_chan = 5'(m_ch);
      if (m_pend && (n == m_due)) begin
         m_pend = 1'b0;
         m_drdy = 1'b1;
         if (p_we) begin
            if (p_addr == 7'h40) m_cfg = p_di;
            else if (p_addr == 7'h41) m_seq_en = p_di[0];
         end else begin
            m_do = p_snap;
         end
      end
   endtask

   initial forever begin
      @(posedge clk_100MHz);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge clk_100MHz);
      if (m_valid) begin
         check("do_out", 32'(do_out), 32'(m_do));
         check("drdy_out", 32'(drdy_out), 32'(m_drdy));
         check("eoc_out", 32'(eoc_out), 32'(m_eoc));
         check("busy_out", 32'(busy_out), 32'(m_busy));
         check("err_out", 32'(err_out), 32'(m_err));
         check("channel_out", 32'(channel_out), 32'(m_chan));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic drp_txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
      bit got;
      got = 1'b0;
      rd  = 16'h0;
      lat = 0;
      @(negedge clk_100MHz);
      daddr_in = a; dwe_in = we; di_in = d; den_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_100MHz);
         den_in = 1'b0;
         if (drdy_out) begin
            got = 1'b1;
            rd  = do_out;
            lat = k;
            break;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL drdy_timeout addr=0x%0h actual=none required=pulse", a);
      end
   endtask

   task automatic wait_eoc(input int bound, output int cyc, output logic [4:0] ch);
      bit got;
      got = 1'b0;
      cyc = 0;
      ch  = 5'd0;
      for (int k = 1; k <= bound; k++) begin
         @(negedge clk_100MHz);
         if (eoc_out) begin
            got = 1'b1;
            cyc = k;
            ch  = channel_out;
            break;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL eoc_timeout actual=none required=pulse within %0d", bound);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int          lat;
      int          cyc;
      logic [4:0]  ch;
      int          neoc;
      int          ndr;
      int          first;
      logic [4:0]  eoc_ch;

      // reset state
      repeat (3) @(negedge clk_100MHz);
      check("rst_do", 32'(do_out), 32'h0);
      check("rst_drdy", 32'(drdy_out), 32'h0);
      check("rst_eoc", 32'(eoc_out), 32'h0);
      check("rst_busy", 32'(busy_out), 32'h0);
      check("rst_err", 32'(err_out), 32'h0);
      check("rst_chan", 32'(channel_out), 32'h0);
      rst = 1'b0;

      // first two conversions after reset
      wait_eoc(100, cyc, ch);
      check("first_eoc_cycles", 32'(cyc), 32'd27);
      check("first_eoc_chan", 32'(ch), 32'd6);
      wait_eoc(100, cyc, ch);
      check("second_eoc_cycles", 32'(cyc), 32'd27);
      check("second_eoc_chan", 32'(ch), 32'd7);
      drp_txn(7'h16, 1'b0, 16'h0, rd, lat);
      check("read_latency", 32'(lat), 32'd4);
`ifdef XADC_DRP_AVG_EN
      check("res_x_first", 32'(rd), 32'h2000);
`else
      check("res_x_first", 32'(rd), 32'h8000);
`endif
      drp_txn(7'h17, 1'b0, 16'h0, rd, lat);
`ifdef XADC_DRP_AVG_EN
      check("res_y_first", 32'(rd), 32'h0FA0);
`else
      check("res_y_first", 32'(rd), 32'h3E80);
`endif

      // scratch register and read-only result
      drp_txn(7'h40, 1'b1, 16'hA5A5, rd, lat);
`ifdef XADC_DRP_AVG_EN
      check("do_hold_after_write", 32'(do_out), 32'h0FA0);
`else
      check("do_hold_after_write", 32'(do_out), 32'h3E80);
`endif
      drp_txn(7'h40, 1'b0, 16'h0, rd, lat);
      check("cfg0_readback", 32'(rd), 32'hA5A5);
      drp_txn(7'h16, 1'b1, 16'h1234, rd, lat);
      drp_txn(7'h16, 1'b0, 16'h0, rd, lat);
`ifndef XADC_DRP_AVG_EN
      check("res_x_write_discarded", 32'(rd), 32'h8000);
`endif
      drp_txn(7'h41, 1'b0, 16'h0, rd, lat);
      check("seqctl_read", 32'(rd), 32'h0001);
      check("err_clean", 32'(err_out), 32'h0);

      // overlapping request sets the sticky error, only one drdy
      @(negedge clk_100MHz);
      daddr_in = 7'h40; dwe_in = 1'b0; den_in = 1'b1;
      ndr = 0;
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk_100MHz);
         if (k == 1) den_in = 1'b0;
         if (k == 2) begin
            check("err_before_overlap", 32'(err_out), 32'h0);
            den_in = 1'b1;
         end
         if (k == 3) begin
            den_in = 1'b0;
            check("err_after_overlap", 32'(err_out), 32'h1);
         end
         if (drdy_out) begin
            ndr++;
            first = k;
         end
      end
      check("overlap_drdy_count", 32'(ndr), 32'd1);
      check("overlap_drdy_cycle", 32'(first), 32'd4);
      repeat (20) @(negedge clk_100MHz);
      check("err_sticky", 32'(err_out), 32'h1);
      rst = 1'b1;
      repeat (2) @(negedge clk_100MHz);
      check("err_cleared_by_rst", 32'(err_out), 32'h0);
      rst = 1'b0;

      // disable the sequencer mid-conversion of channel 6
      repeat (8) @(negedge clk_100MHz);
      drp_txn(7'h41, 1'b1, 16'h0000, rd, lat);
      neoc = 0;
      eoc_ch = 5'd0;
      for (int k = 0; k < 230; k++) begin
         @(negedge clk_100MHz);
         if (eoc_out) begin
            neoc++;
            eoc_ch = channel_out;
         end
      end
      check("disable_eoc_count", 32'(neoc), 32'd1);
      check("disable_eoc_chan", 32'(eoc_ch), 32'd6);
      check("disable_busy", 32'(busy_out), 32'h0);
      drp_txn(7'h41, 1'b1, 16'h0001, rd, lat);
      wait_eoc(100, cyc, ch);
      check("reenable_chan", 32'(ch), 32'd6);

      // randomized traffic, occasional resets and sample changes
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_100MHz);
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 15) == 0) sample_x = 12'($urandom);
         if ($urandom_range(0, 15) == 0) sample_y = 12'($urandom);
         den_in = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0:       daddr_in = 7'h16;
            1:       daddr_in = 7'h17;
            2:       daddr_in = 7'h40;
            3:       daddr_in = 7'h41;
            default: daddr_in = 7'($urandom);
         endcase
         dwe_in = 1'($urandom_range(0, 1));
         di_in  = 16'($urandom);
         if (daddr_in == 7'h41 && $urandom_range(0, 3) != 0) di_in[0] = 1'b1;
      end
      @(negedge clk_100MHz);
      rst    = 1'b0;
      den_in = 1'b0;
      repeat (10) @(negedge clk_100MHz);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
